// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Two-entry skid FIFO that captures the ALU result together with its flags
//   and operation tag, decoupling the ALU from a back-pressuring consumer.
//
//   Entries are kept as a head/tail pair.  The head register drives out_*
//   directly, so the output data is a flop (stable under stall) and is 0
//   whenever the stage is empty.
//
//   in_ready is registered from the next occupancy, so it never depends
//   combinationally on out_ready.  A full stage therefore refuses a push even
//   in a cycle where it is also popping.
//
// Optional feature:
//   ALU_RESULT_STICKY_FLAGS_EN - when defined, sticky_flags ORs together the
//   flags of every popped entry until sticky_clr.  When it is undefined,
//   sticky_flags is tied to 0 and sticky_clr is ignored.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         producer handshake
//   in_result, in_c/z/o/s       ALU result and carry/zero/overflow/sign
//   in_opsel, in_mode           operation tag carried with the result
//   out_valid / out_ready       consumer handshake
//   out_result, out_flags       head entry; out_flags = {c,z,o,s}
//   out_opsel, out_mode         head entry tag
//   occupancy                   held entries, 0..2
//   sticky_clr, sticky_flags    accumulated-flags clear and value
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int DWIDTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_result,
    input  logic              in_c,
    input  logic              in_z,
    input  logic              in_o,
    input  logic              in_s,
    input  logic [2:0]        in_opsel,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic [2:0]        out_opsel,
    output logic              out_mode,
    output logic [1:0]        occupancy,
    input  logic              sticky_clr,
    output logic [3:0]        sticky_flags
);

    typedef struct packed {
        logic [DWIDTH-1:0] result;
        logic [3:0]        flags;
        logic [2:0]        opsel;
        logic              mode;
    } entry_t;

    entry_t     r_head, r_tail;
    logic [1:0] r_occ;
    logic       r_in_ready;

    entry_t     w_new;
    entry_t     w_head_nxt, w_tail_nxt;
    logic [1:0] w_occ_nxt;
    logic       w_push, w_pop;

    assign w_new = '{result: in_result,
                     flags:  {in_c, in_z, in_o, in_s},
                     opsel:  in_opsel,
                     mode:   in_mode};

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_occ != 2'd0) && out_ready;

    always_comb begin
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        w_occ_nxt  = r_occ;
        case (r_occ)
            2'd0: begin
                if (w_push) begin
                    w_head_nxt = w_new;
                    w_occ_nxt  = 2'd1;
                end
            end
            2'd1: begin
                case ({w_push, w_pop})
                    2'b10: begin
                        w_tail_nxt = w_new;
                        w_occ_nxt  = 2'd2;
                    end
                    2'b01: begin
                        // Clear the head so that out_* reads 0 when empty.
                        w_head_nxt = '0;
                        w_occ_nxt  = 2'd0;
                    end
                    2'b11: begin
                        w_head_nxt = w_new;
                    end
                    default: ;
                endcase
            end
            2'd2: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_head_nxt = r_tail;
                    w_tail_nxt = '0;
                    w_occ_nxt  = 2'd1;
                end
            end
            default: begin
                w_head_nxt = '0;
                w_tail_nxt = '0;
                w_occ_nxt  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_occ      <= w_occ_nxt;
            r_in_ready <= (w_occ_nxt < 2'd2);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_occ != 2'd0);
    assign out_result = r_head.result;
    assign out_flags  = r_head.flags;
    assign out_opsel  = r_head.opsel;
    assign out_mode   = r_head.mode;
    assign occupancy  = r_occ;

`ifdef ALU_RESULT_STICKY_FLAGS_EN
    logic [3:0] r_sticky;

    // A clear and a pop in the same cycle leaves only the popped flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 4'd0;
        end else if (w_pop) begin
            r_sticky <= sticky_clr ? r_head.flags : (r_sticky | r_head.flags);
        end else if (sticky_clr) begin
            r_sticky <= 4'd0;
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_sticky_clr;
    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_flags        = 4'd0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//   Scoreboard bench for alu_result_stage.  The driver pushes an expected
//   entry into a queue for every accepted input.  An independent monitor
//   checks occupancy, ready and valid against the queue depth, and pops and
//   compares the head whenever the DUT hands an entry to the consumer.
//   Inputs change on the falling edge.  The monitor samples at falling edge
//   plus 1 and the driver records a push at falling edge plus 3, both before
//   the next rising edge.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

    localparam int DW = 128;

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_result;
    logic          in_c, in_z, in_o, in_s;
    logic [2:0]    in_opsel;
    logic          in_mode;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_result;
    logic [3:0]    out_flags;
    logic [2:0]    out_opsel;
    logic          out_mode;
    logic [1:0]    occupancy;
    logic          sticky_clr;
    logic [3:0]    sticky_flags;

    alu_result_stage #(.DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_c(in_c), .in_z(in_z), .in_o(in_o), .in_s(in_s),
        .in_opsel(in_opsel), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_opsel(out_opsel), .out_mode(out_mode),
        .occupancy(occupancy), .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] r;
        logic [3:0]    f;
        logic [2:0]    op;
        logic          m;
    } ent_t;

    ent_t       q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       rdy_ok;
    logic [3:0] exp_sticky = 4'd0;
    bit         chk_z = 0;
    bit         rnd_ordy = 0;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // in_ready is only expected once a clock edge has been seen out of reset.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) rdy_ok <= 1'b0;
        else        rdy_ok <= 1'b1;

    // Monitor / scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            check("occupancy", occupancy, q.size());
            check("in_ready", in_ready, rdy_ok && q.size() < 2);
            check("out_valid", out_valid, q.size() != 0);
            check("sticky_flags", sticky_flags, exp_sticky);
            if (q.size() == 0) begin
                check("empty_result", out_result, 0);
                check("empty_tag", {out_flags, out_opsel, out_mode}, 0);
`ifdef ALU_RESULT_STICKY_FLAGS_EN
                if (sticky_clr) exp_sticky = 4'd0;
`endif
            end else begin
                check("out_result", out_result, q[0].r);
                check("out_flags", out_flags, q[0].f);
                check("out_opsel", out_opsel, q[0].op);
                check("out_mode", out_mode, q[0].m);
                if (chk_z) check("z_vs_result", out_flags[2], out_result == 0);
                if (out_ready) begin
`ifdef ALU_RESULT_STICKY_FLAGS_EN
                    exp_sticky = sticky_clr ? q[0].f : (exp_sticky | q[0].f);
`endif
                    void'(q.pop_front());
                end else begin
`ifdef ALU_RESULT_STICKY_FLAGS_EN
                    if (sticky_clr) exp_sticky = 4'd0;
`endif
                end
            end
        end
    end

    // One cycle of stimulus.  Returns whether the offered entry was accepted.
    task automatic drive(input bit v, input logic [DW-1:0] r, input logic [3:0] f,
                         input logic [2:0] op, input logic m, input bit ordy,
                         input bit clr, output bit acc);
        ent_t e;
        @(negedge clk);
        in_valid   = v;
        in_result  = r;
        {in_c, in_z, in_o, in_s} = f;
        in_opsel   = op;
        in_mode    = m;
        out_ready  = rnd_ordy ? 1'($urandom_range(0, 1)) : ordy;
        sticky_clr = clr;
        #3;
        acc = v && in_ready;
        if (acc) begin
            e.r = r; e.f = f; e.op = op; e.m = m;
            q.push_back(e);
        end
    endtask

    // Keep offering one entry until accepted, within a cycle budget.
    task automatic send(input logic [DW-1:0] r, input logic [3:0] f, input logic [2:0] op,
                        input logic m, input bit ordy, input bit clr);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 100) begin
            drive(1'b1, r, f, op, m, ordy, clr, acc);
            n++;
        end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 4'd0, 3'd0, 1'b0, ordy, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            idle(1, 1'b1);
            n++;
        end
        idle(1, 1'b1);
        check("drain_left", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        logic [DW-1:0] r;
        logic [3:0]    f;

        rst_n = 1'b0;
        in_valid = 0; in_result = '0; {in_c, in_z, in_o, in_s} = 4'd0;
        in_opsel = 3'd0; in_mode = 0; out_ready = 0; sticky_clr = 0;

        // Reset state.
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_result", out_result, 0);
        check("rst_sticky", sticky_flags, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single push, one-cycle latency.
        idle(1, 1'b1);
        send(5, 4'b0000, 3'd1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Fill to two; third entry held off; then drain in order.
        send(1, 4'b0000, 3'd2, 1'b1, 1'b0, 1'b0);
        send(2, 4'b0000, 3'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3, 4'b0000, 3'd4, 1'b1, 1'b0, 1'b0, acc);
            check("held_off", acc, 0);
        end
        send(3, 4'b0000, 3'd4, 1'b1, 1'b1, 1'b0);
        drain();

        // Occupancy 1: push and pop together.
        send(7, 4'b0000, 3'd5, 1'b0, 1'b0, 1'b0);
        send(9, 4'b0000, 3'd6, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("pushpop_occ", occupancy, 1);
        check("pushpop_head", out_result, 9);
        drain();

        // Sticky flags accumulate, then clear together with a pop.
        send(11, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0);
        send(12, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0);
        drain();
`ifdef ALU_RESULT_STICKY_FLAGS_EN
        check("sticky_acc", sticky_flags, 4'b1001);
`else
        check("sticky_acc", sticky_flags, 4'b0000);
`endif
        send(13, 4'b0100, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, acc);
        idle(1, 1'b1);
`ifdef ALU_RESULT_STICKY_FLAGS_EN
        check("sticky_clr_pop", sticky_flags, 4'b0100);
`else
        check("sticky_clr_pop", sticky_flags, 4'b0000);
`endif

        // Reset while full, asserted between clock edges.
        send(21, 4'b1111, 3'd7, 1'b1, 1'b0, 1'b0);
        send(22, 4'b1010, 3'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #4;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_occupancy", occupancy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_result", out_result, 0);
        check("midrst_out_tag", {out_flags, out_opsel, out_mode}, 0);
        check("midrst_sticky", sticky_flags, 0);
        q.delete();
        exp_sticky = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1);

        // Random traffic with random back-pressure.
        chk_z = 1;
        rnd_ordy = 1;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       r = '1;
                1:       r = '0;
                default: r = {$urandom, $urandom, $urandom, $urandom};
            endcase
            f = {1'($urandom_range(0, 1)), r == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 3) == 0) idle(1, 1'b0);
            send(r, f, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0,
                 $urandom_range(0, 15) == 0);
        end
        rnd_ordy = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DWIDTH, default 128, width of the captured ALU result; SHALL match the producing ALU.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  ALU result/flags valid this cycle.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 in_result  input  DWIDTH  ALU result.
REQ-007 in_c, in_z, in_o, in_s  input  1 each  ALU carry/zero/overflow/sign flags.
REQ-008 in_opsel  input  3; in_mode  input  1  operation tag carried with the result.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 out_result  output  DWIDTH; out_flags  output  4  {c,z,o,s} at bits [3:0] MSB-first; out_opsel  output  3; out_mode  output  1.
REQ-012 occupancy  output  2  number of held entries, 0..2.
REQ-013 sticky_clr  input  1; sticky_flags  output  4  accumulated {c,z,o,s} (see Configuration).

Function
REQ-014 Stage SHALL be a 2-entry FIFO holding {result, flags, opsel, mode} per entry.
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL be a register equal to (next occupancy < 2); it SHALL NOT combinationally depend on out_ready.
REQ-017 out_valid SHALL equal (occupancy != 0); out_* SHALL present the oldest entry.
REQ-018 Latency: an entry pushed in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1 when occupancy was 0.
REQ-019 While out_valid && !out_ready, out_result, out_flags, out_opsel, out_mode SHALL remain stable.
REQ-020 Occupancy 1, push and pop same cycle: occupancy stays 1, new entry becomes head next cycle.
REQ-021 Occupancy 2: in_ready=0, in_valid ignored; pop drops occupancy to 1 and in_ready returns to 1 next cycle.
REQ-022 Occupancy 0: out_ready ignored, no pop, out_* data SHALL be 0.
REQ-023 Entries SHALL be delivered in push order with no loss or duplication.

Reset
REQ-024 rst_n low SHALL asynchronously clear occupancy, both entries, out_valid, out_result, out_flags, out_opsel, out_mode, sticky_flags to 0 and in_ready to 0.
REQ-025 in_ready SHALL go to 1 on the first rising clk edge after rst_n deasserts.
REQ-026 Reset asserted mid-transfer SHALL discard all held entries; no entry from before reset SHALL appear afterwards.

Configuration
REQ-027 Macro ALU_RESULT_STICKY_FLAGS_EN SHALL select sticky flag accumulation.
REQ-028 With macro defined: on each pop, sticky_flags SHALL become sticky_flags | popped out_flags; sticky_clr=1 SHALL clear to 0 next edge; clr and pop same cycle SHALL yield exactly the popped entry's flags.
REQ-029 Without macro: sticky_flags SHALL be constant 0, sticky_clr ignored, no accumulation logic built.

Verification
REQ-030 Reset release, in_valid=1, in_result=5, flags=0000, out_ready=1 -> cycle after push out_valid=1, out_result=5; in_ready=1 throughout after first edge.
REQ-031 out_ready=0, push A=1 then B=2 -> occupancy=2, in_ready=0, third push C=3 held off; then out_ready=1 -> outputs 1,2,3 in order, no loss.
REQ-032 Occupancy 1 (head=7), simultaneous push 9 and pop -> occupancy stays 1, next head=9.
REQ-033 With ALU_RESULT_STICKY_FLAGS_EN: pop flags 1000 then 0001 -> sticky_flags=1001; sticky_clr with pop of 0100 -> sticky_flags=0100; without macro sticky_flags=0000 throughout.
REQ-034 Occupancy 2, assert rst_n=0 between edges -> all outputs 0 immediately, in_ready=0; after release out_valid stays 0 until a new push.
REQ-035 Random valid/ready backpressure, 1000 entries, DWIDTH=128 with all-ones and zero results -> output stream equals input stream, out_flags z bit matches result==0 per entry.
